// File: rtl/xor_accum_pkg.sv
// Shared definitions for the xor_accum streaming XOR accumulator:
// default parameter values, the output-register state encoding and the
// saturating increment used by the beat counter.
package xor_accum_pkg;

    localparam int XOR_ACCUM_WIDTH_DEF  = 8;
    localparam int XOR_ACCUM_LANES_DEF  = 2;
    localparam int XOR_ACCUM_BEAT_W_DEF = 16;

    // ACCUM: output register empty; HOLD: a result waits for the consumer.
    // The encoding matches out_valid so the state bit drives it directly.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } xor_accum_state_t;

    // Increment value by one, clamping at the all-ones value of a
    // counter that is width bits wide (width up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_value;
        max_value = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/xor_lane_fold.sv
// Combinational XOR fold of LANES words of WIDTH bits into one word.
// Lane k sits at in_data[k*WIDTH +: WIDTH]; with LANES=1 lane 0 passes
// through unchanged.
module xor_lane_fold #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic [WIDTH*LANES-1:0] in_data,
    output logic [WIDTH-1:0]       fold
);

    // XOR every lane word into a single result word.
    always_comb begin
        fold = '0;
        for (int k = 0; k < LANES; k++) begin
            fold = fold ^ in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/xor_accum.sv
// Streaming multi-lane XOR accumulator. Each accepted beat is lane-folded,
// XOR-accumulated across a frame, and the frame result plus a saturating
// beat count is presented on a valid/ready output register.
// Optional feature macro: XOR_ACCUM_PARITY_EN adds the registered
// out_parity output (XOR-reduce of out_data).
module xor_accum
    import xor_accum_pkg::*;
#(
    parameter int WIDTH  = XOR_ACCUM_WIDTH_DEF,
    parameter int LANES  = XOR_ACCUM_LANES_DEF,
    parameter int BEAT_W = XOR_ACCUM_BEAT_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [BEAT_W-1:0]      out_beats,
    output logic                   out_valid,
`ifdef XOR_ACCUM_PARITY_EN
    output logic                   out_parity,
`endif
    input  logic                   out_ready
);

    xor_accum_state_t  state;
    xor_accum_state_t  state_next;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    logic [BEAT_W-1:0] cnt;
    logic [BEAT_W-1:0] cnt_next;
    logic [WIDTH-1:0]  out_data_next;
    logic [BEAT_W-1:0] out_beats_next;
    logic [WIDTH-1:0]  fold;
    logic [WIDTH-1:0]  frame_result;
    logic [BEAT_W-1:0] cnt_inc;
    logic              accept;
    logic              out_fire;

    xor_lane_fold #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_fold (
        .in_data (in_data),
        .fold    (fold)
    );

    assign out_valid    = (state == HOLD);
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign frame_result = acc ^ fold;
    assign cnt_inc      = BEAT_W'(sat_inc(32'(cnt), BEAT_W));

    // Next-state logic: fold accepted beats into the frame, close the frame
    // into the output register on a last beat, and free the register when
    // the consumer takes it unless a new result replaces it in the same cycle.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        out_data_next  = out_data;
        out_beats_next = out_beats;
        if (out_fire) begin
            state_next = ACCUM;
        end
        if (accept) begin
            if (in_last) begin
                out_data_next  = frame_result;
                out_beats_next = cnt_inc;
                state_next     = HOLD;
                acc_next       = '0;
                cnt_next       = '0;
            end else begin
                acc_next = frame_result;
                cnt_next = cnt_inc;
            end
        end
    end

    // State, accumulator, counter and output register; synchronous reset
    // discards any partial frame and any held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_data  <= out_data_next;
            out_beats <= out_beats_next;
        end
    end

`ifdef XOR_ACCUM_PARITY_EN
    // Parity register loads alongside out_data and holds with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (accept && in_last) begin
            out_parity <= ^frame_result;
        end
    end
`endif

endmodule

// File: tb/tb_xor_accum.sv
// Directed testbench for xor_accum. A default instance (BEAT_W=16) and a
// narrow-counter instance (BEAT_W=2) share the input stimulus.
// Honours XOR_ACCUM_PARITY_EN for the optional out_parity port.
module tb_xor_accum;

    logic        clock;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [7:0]  out_data;
    logic [15:0] out_beats;
    logic        out_valid;
    logic        sat_in_ready;
    logic [7:0]  sat_out_data;
    logic [1:0]  sat_out_beats;
    logic        sat_out_valid;
`ifdef XOR_ACCUM_PARITY_EN
    logic        out_parity;
    logic        sat_out_parity;
`endif

    int checkCount;
    int passCount;

    xor_accum #(.WIDTH(8), .LANES(2), .BEAT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_beats  (out_beats),
        .out_valid  (out_valid),
`ifdef XOR_ACCUM_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_ready  (out_ready)
    );

    xor_accum #(.WIDTH(8), .LANES(2), .BEAT_W(2)) dut_sat (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (sat_in_ready),
        .out_data   (sat_out_data),
        .out_beats  (sat_out_beats),
        .out_valid  (sat_out_valid),
`ifdef XOR_ACCUM_PARITY_EN
        .out_parity (sat_out_parity),
`endif
        .out_ready  (out_ready)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one beat (or idle), take one rising edge, settle 1 unit past it.
    task automatic applyStimulus(input logic [15:0] data, input logic valid,
                                 input logic last);
        in_data  = data;
        in_valid = valid;
        in_last  = last;
        @(posedge clock);
        #1;
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // 1: reset for two cycles, then release
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_data",  32'(out_data),  32'h00);
        checkOutput("rst_beats", 32'(out_beats), 32'h0);
        checkOutput("rst_ready", 32'(in_ready),  32'h1);
`ifdef XOR_ACCUM_PARITY_EN
        checkOutput("rst_parity", 32'(out_parity), 32'h0);
`endif

        // 2: single-beat frame 0xA55A -> 0xA5^0x5A = 0xFF, valid one cycle
        applyStimulus(16'hA55A, 1'b1, 1'b1);
        checkOutput("single_data",  32'(out_data),  32'hFF);
        checkOutput("single_beats", 32'(out_beats), 32'h1);
        checkOutput("single_valid", 32'(out_valid), 32'h1);
`ifdef XOR_ACCUM_PARITY_EN
        checkOutput("single_parity", 32'(out_parity), 32'h0);
`endif
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("single_drop", 32'(out_valid), 32'h0);

        // 3: three-beat frame: 0x03 ^ 0x0C ^ 0x30 = 0x3F
        applyStimulus(16'h0102, 1'b1, 1'b0);
        checkOutput("multi_mid_valid", 32'(out_valid), 32'h0);
        applyStimulus(16'h0408, 1'b1, 1'b0);
        applyStimulus(16'h1020, 1'b1, 1'b1);
        checkOutput("multi_data",  32'(out_data),  32'h3F);
        checkOutput("multi_beats", 32'(out_beats), 32'h3);
        checkOutput("multi_valid", 32'(out_valid), 32'h1);

        // 4: backpressure holds 0x3F, then handshake with a new last beat
        out_ready = 1'b0;
        in_data   = 16'h1111;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        #1;
        checkOutput("bp_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'h1111, 1'b1, 1'b1);
            checkOutput("bp_hold_data",  32'(out_data),  32'h3F);
            checkOutput("bp_hold_beats", 32'(out_beats), 32'h3);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
        applyStimulus(16'h00F0, 1'b1, 1'b1);
        checkOutput("swap_data",  32'(out_data),  32'hF0);
        checkOutput("swap_beats", 32'(out_beats), 32'h1);
        checkOutput("swap_valid", 32'(out_valid), 32'h1);

        // back-to-back single-beat frames at full rate
        applyStimulus(16'h0001, 1'b1, 1'b1);
        checkOutput("b2b_first",  32'(out_data),  32'h01);
        applyStimulus(16'h0300, 1'b1, 1'b1);
        checkOutput("b2b_second", 32'(out_data),  32'h03);
        checkOutput("b2b_beats",  32'(out_beats), 32'h1);
        checkOutput("b2b_valid",  32'(out_valid), 32'h1);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("b2b_drop",   32'(out_valid), 32'h0);

        // 5: reset during an open frame discards the partial result
        applyStimulus(16'h1234, 1'b1, 1'b0);
        applyStimulus(16'h5678, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_ready", 32'(in_ready),  32'h1);
        applyStimulus(16'h00FF, 1'b1, 1'b1);
        checkOutput("midrst_data",  32'(out_data),  32'hFF);
        checkOutput("midrst_beats", 32'(out_beats), 32'h1);

        // reset while a result is held
        out_ready = 1'b0;
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        checkOutput("holdrst_valid", 32'(out_valid), 32'h0);
        checkOutput("holdrst_data",  32'(out_data),  32'h00);
        checkOutput("holdrst_beats", 32'(out_beats), 32'h0);

        // 6: six-beat frame; 2-bit counter saturates at 3, 16-bit counts 6
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0100, 1'b1, 1'b0);
        end
        applyStimulus(16'h0006, 1'b1, 1'b1);
        checkOutput("sat_beats", 32'(sat_out_beats), 32'h3);
        checkOutput("sat_data",  32'(sat_out_data),  32'h07);
        checkOutput("sat_valid", 32'(sat_out_valid), 32'h1);
        checkOutput("wide_beats", 32'(out_beats),    32'h6);
        checkOutput("wide_data",  32'(out_data),     32'h07);
`ifdef XOR_ACCUM_PARITY_EN
        checkOutput("sat_parity",  32'(sat_out_parity), 32'h1);
        checkOutput("wide_parity", 32'(out_parity),     32'h1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
